// File: rtl/spart_pkg.sv
// Shared definitions for the SPART serial transmitter and receiver:
// frame-sequencer state encoding, default oversampling ratio and frame size.
package spart_pkg;

    // Frame sequencer states, shared with spart_rx so both sides agree on encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } spart_state_e;

    // Enable pulses per bit period at the default baud tick rate.
    localparam int OVERSAMPLE_DEF = 16;

    // Start bit + 8 data bits + stop bit.
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/spart_tx.sv
// SPART transmitter: double-buffered 8N1 serializer.
// A one-byte holding register accepts writes while the shift register sends
// the current frame LSB first; bit timing comes from the external baud tick.
module spart_tx
    import spart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       wr,
    input  logic [7:0] data_in,
    output logic       txd,
    output logic       tbr,
    output logic       tx_busy
);

    // Last tick count of a bit period; the counter is 4 bits wide.
    localparam logic [3:0] TICK_LAST     = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_DATA_BIT = 3'd7;

    spart_state_e state_r;
    spart_state_e state_s;
    logic [3:0]   tick_cnt_r;
    logic [3:0]   tick_cnt_s;
    logic [2:0]   bit_cnt_r;
    logic [2:0]   bit_cnt_s;
    logic [7:0]   shift_r;
    logic [7:0]   shift_s;
    logic [7:0]   hold_r;
    logic [7:0]   hold_s;
    logic         hold_valid_r;
    logic         hold_valid_s;
    logic         txd_r;
    logic         txd_s;
    logic         tbr_r;
    logic         busy_r;
    logic         bit_end_s;
    logic         wr_accept_s;
    logic         load_s;

    // A bit period closes on the enable pulse that finds the counter at its last value.
    assign bit_end_s = enable & (tick_cnt_r == TICK_LAST);

    // tbr mirrors the holding register being empty, so writes are only taken then.
    assign wr_accept_s = wr & tbr_r;

    // Next-state, counter, shifter and holding-register logic.
    always_comb begin
        state_s      = state_r;
        tick_cnt_s   = tick_cnt_r;
        bit_cnt_s    = bit_cnt_r;
        shift_s      = shift_r;
        hold_s       = hold_r;
        hold_valid_s = hold_valid_r;
        load_s       = 1'b0;

        // Ticks only advance while a frame is on the line.
        if ((state_r != ST_IDLE) && enable) begin
            if (bit_end_s) begin
                tick_cnt_s = 4'd0;
            end else begin
                tick_cnt_s = tick_cnt_r + 4'd1;
            end
        end else begin
            tick_cnt_s = tick_cnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                // Leaving idle does not wait for a tick, so a write starts
                // the start bit two clocks later regardless of tick phase.
                if (hold_valid_r) begin
                    load_s  = 1'b1;
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_s   = ST_DATA;
                    bit_cnt_s = 3'd0;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_cnt_r == LAST_DATA_BIT) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_STOP: begin
                // A waiting byte goes straight into a new start bit: no idle gap.
                if (bit_end_s) begin
                    if (hold_valid_r) begin
                        load_s  = 1'b1;
                        state_s = ST_START;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (load_s) begin
            shift_s      = hold_r;
            hold_valid_s = 1'b0;
            tick_cnt_s   = 4'd0;
        end else begin
            shift_s = shift_s;
        end

        // Load and accept are exclusive: accept needs an empty holding register.
        if (wr_accept_s) begin
            hold_s       = data_in;
            hold_valid_s = 1'b1;
        end else begin
            hold_s = hold_s;
        end
    end

    // Line level for the state being entered, so txd can be registered.
    always_comb begin
        txd_s = 1'b1;
        case (state_s)
            ST_IDLE:  txd_s = 1'b1;
            ST_START: txd_s = 1'b0;
            ST_DATA:  txd_s = shift_s[0];
            ST_STOP:  txd_s = 1'b1;
            default:  txd_s = 1'b1;
        endcase
    end

    // State and datapath registers; reset aborts any frame and empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            tick_cnt_r   <= 4'd0;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            hold_r       <= 8'h00;
            hold_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            tick_cnt_r   <= tick_cnt_s;
            bit_cnt_r    <= bit_cnt_s;
            shift_r      <= shift_s;
            hold_r       <= hold_s;
            hold_valid_r <= hold_valid_s;
        end
    end

    // Registered outputs; reset drives the line high immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd_r  <= 1'b1;
            tbr_r  <= 1'b1;
            busy_r <= 1'b0;
        end else begin
            txd_r  <= txd_s;
            tbr_r  <= ~hold_valid_s;
            busy_r <= (state_s != ST_IDLE);
        end
    end

    assign txd     = txd_r;
    assign tbr     = tbr_r;
    assign tx_busy = busy_r;

endmodule

// File: tb/tb_spart_tx.sv
// Testbench for spart_tx: randomized baud ticks and writes, a frame-level
// reference model feeding a scoreboard queue, and a serial-line monitor.
module tb_spart_tx;

    localparam int OS     = 16;
    localparam int NBITS  = 10;
    localparam int FRAME  = OS * NBITS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable;
    logic       wr;
    logic [7:0] data_in;
    logic       txd;
    logic       tbr;
    logic       tx_busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int         en_mode = 0;

    // reference model state
    int         m_left;
    logic       m_hold_v;
    logic [7:0] m_hold;
    logic [7:0] m_cur;

    logic mon_in_frame = 1'b0;

    spart_tx #(.OVERSAMPLE(OS)) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .wr      (wr),
        .data_in (data_in),
        .txd     (txd),
        .tbr     (tbr),
        .tx_busy (tx_busy)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line level: position within a frame decides the bit.
    function automatic logic model_txd();
        int pos;
        int b;
        if (m_left == 0) return 1'b1;
        pos = FRAME - m_left;
        b   = pos / OS;
        if (b == 0) return 1'b0;
        if (b == NBITS - 1) return 1'b1;
        return m_cur[b-1];
    endfunction

    // Baud tick driver.
    initial begin
        enable = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (en_mode)
                0:       enable = ($urandom_range(0, 1) == 1);
                1:       enable = 1'b1;
                default: enable = 1'b0;
            endcase
        end
    end

    // Reference model: frame counted in remaining enable pulses.
    initial begin
        logic old_hv;
        m_left = 0; m_hold_v = 1'b0; m_hold = 8'h00; m_cur = 8'h00;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_left   = 0;
                m_hold_v = 1'b0;
                m_hold   = 8'h00;
                exp_q.delete();
            end else begin
                old_hv = m_hold_v;
                if (m_left == 0) begin
                    if (m_hold_v) begin
                        m_left = FRAME; m_cur = m_hold; m_hold_v = 1'b0;
                    end
                end else if (enable) begin
                    m_left--;
                    if (m_left == 0 && m_hold_v) begin
                        m_left = FRAME; m_cur = m_hold; m_hold_v = 1'b0;
                    end
                end
                if (wr && !old_hv) begin
                    m_hold_v = 1'b1;
                    m_hold   = data_in;
                    exp_q.push_back(data_in);
                end
            end
        end
    end

    // Per-cycle output check against the model.
    initial forever begin
        @(negedge clk);
        check("txd", txd, model_txd());
        check("tbr", tbr, !m_hold_v);
        check("tx_busy", tx_busy, m_left != 0);
    end

    // Monitor: samples the line once per enable, assembles frames, pops scoreboard.
    initial begin
        logic       samp[FRAME];
        int         idx;
        int         errs;
        int         b;
        logic       e;
        logic [7:0] want;
        logic [7:0] dec;
        idx = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_in_frame = 1'b0;
            end else if (enable) begin
                if (!mon_in_frame) begin
                    if (txd == 1'b0) begin
                        mon_in_frame = 1'b1;
                        samp[0] = 1'b0;
                        idx = 1;
                    end
                end else begin
                    samp[idx] = txd;
                    idx++;
                    if (idx == FRAME) begin
                        mon_in_frame = 1'b0;
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL frame: unexpected frame, none queued at %0t", $time);
                        end else begin
                            want = exp_q.pop_front();
                            errs = 0;
                            for (int i = 0; i < FRAME; i++) begin
                                b = i / OS;
                                e = (b == 0) ? 1'b0 : (b == NBITS - 1) ? 1'b1 : want[b-1];
                                if (samp[i] !== e) errs++;
                            end
                            for (int k = 0; k < 8; k++) dec[k] = samp[(k + 1) * OS + OS / 2];
                            check("frame_byte", dec, want);
                            check("frame_shape_errs", errs, 0);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is at posedge+1; wr is held for exactly one cycle.
    task automatic do_wr(input logic [7:0] b);
        wr = 1'b1;
        data_in = b;
        tick();
        wr = 1'b0;
    endtask

    task automatic wait_tbr_high();
        int n = 0;
        while (tbr !== 1'b1 && n < 2000) begin tick(); n++; end
        if (n >= 2000) begin total++; bad++; $display("FAIL wait_tbr: timeout got %b expected 1", tbr); end
    endtask

    task automatic wait_txd_low();
        int n = 0;
        @(negedge clk);
        while (txd !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) begin total++; bad++; $display("FAIL wait_txd_low: timeout got %b expected 0", txd); end
    endtask

    task automatic count_busy_enables(output int cnt);
        int n = 0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (tx_busy !== 1'b1 || n > 5000) break;
            if (enable) cnt++;
            n++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(tx_busy === 1'b0 && tbr === 1'b1 && !mon_in_frame && exp_q.size() == 0) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) begin
            total++; bad++;
            $display("FAIL wait_idle: timeout busy=%b tbr=%b queued=%0d expected idle", tx_busy, tbr, exp_q.size());
        end
    endtask

    initial begin
        int cnt;
        int chg;
        logic ref_txd;
        wr = 1'b0;
        data_in = 8'h00;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_tbr", tbr, 1'b1);
        check("rst_busy", tx_busy, 1'b0);

        // single frame 0xA5
        tick();
        do_wr(8'hA5);
        @(negedge clk);
        check("a5_tbr_low", tbr, 1'b0);
        check("a5_txd_idle", txd, 1'b1);
        count_busy_enables(cnt);
        check("a5_busy_enables", cnt, FRAME);
        wait_idle();

        // back-to-back 0x00 then 0xFF written on tbr rise
        tick();
        do_wr(8'h00);
        wait_tbr_high();
        fork
            do_wr(8'hFF);
            count_busy_enables(cnt);
        join
        check("b2b_busy_enables", cnt, 2 * FRAME);
        wait_idle();

        // write while holding register full is ignored
        tick();
        do_wr(8'h11);
        wait_tbr_high();
        do_wr(8'h22);
        repeat (20) tick();
        do_wr(8'h3C);
        @(negedge clk);
        check("ignored_wr_tbr", tbr, 1'b0);
        wait_idle();

        // reset mid-frame, then a clean frame
        tick();
        do_wr(8'h55);
        wait_txd_low();
        cnt = enable ? 1 : 0;
        while (cnt < 70) begin @(negedge clk); if (enable) cnt++; end
        tick();
        rst = 1'b1;
        #1;
        check("midrst_txd", txd, 1'b1);
        check("midrst_tbr", tbr, 1'b1);
        check("midrst_busy", tx_busy, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        do_wr(8'h81);
        wait_idle();

        // freeze ticks for 1000 cycles mid-DATA
        tick();
        do_wr(8'hC3);
        wait_txd_low();
        cnt = enable ? 1 : 0;
        while (cnt < 50) begin @(negedge clk); if (enable) cnt++; end
        en_mode = 2;
        @(negedge clk);
        ref_txd = txd;
        chg = 0;
        repeat (1000) begin
            @(negedge clk);
            if (txd !== ref_txd || tx_busy !== 1'b1) chg++;
        end
        check("freeze_changes", chg, 0);
        en_mode = 0;
        wait_idle();

        // enable tied high: frame is exactly FRAME clocks
        en_mode = 1;
        tick();
        do_wr(8'hE7);
        wait_txd_low();
        cnt = 0;
        while (tx_busy === 1'b1 && cnt < 1000) begin cnt++; @(negedge clk); end
        check("tied_enable_cycles", cnt, FRAME);
        en_mode = 0;
        wait_idle();

        // random writes, some landing while the buffer is full
        for (int k = 0; k < 25; k++) begin
            tick();
            repeat ($urandom_range(0, 80)) tick();
            do_wr(8'($urandom_range(0, 255)));
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
